ascii_num_stream_sep: RTL and testbench

ASCII_NUM_STREAM_SEP -- requirements
Module: ascii_num_stream_sep

---
 rtl/ascii_num_stream_sep.sv | 183 ++++++++++++++++++
 tb/tb_ascii_num_stream_sep.sv | 359 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ascii_num_stream_sep.sv
// Streaming ASCII integer parser: splits a byte packet into signed numbers and
// writes each one to an external RAM port as soon as its terminator arrives.
module ascii_num_stream_sep #(
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH      = 2048,
  parameter int ADDR_WIDTH = 11,
  parameter int SAT_MODE   = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  clear,
  input  logic [7:0]            pkt_payload_data,
  input  logic                  pkt_payload_valid,
  input  logic                  pkt_payload_last,
  output logic                  pkt_payload_ready,
  output logic                  wr_en,
  output logic [ADDR_WIDTH-1:0] wr_addr,
  output logic [DATA_WIDTH-1:0] wr_data,
  output logic                  done,
  output logic                  invalid,
  output logic                  overflow,
  output logic                  full,
  output logic [ADDR_WIDTH:0]   num_count,
  output logic [1:0]            state_dbg
);

  // Handshake: a byte is consumed on every rising edge where
  // pkt_payload_valid && pkt_payload_ready; the source holds data/last stable
  // until then. ready is low only in DONE, until clear or rst.
  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_NUM  = 2'd1,
    S_DONE = 2'd2,
    S_ERR  = 2'd3
  } state_t;

  localparam int                  MW        = DATA_WIDTH + 4;
  localparam logic [MW-1:0]       LIMIT     = MW'(1) << (DATA_WIDTH - 1);
  localparam logic [DATA_WIDTH-1:0] LIMIT_W = LIMIT[DATA_WIDTH-1:0];
  localparam logic [DATA_WIDTH-1:0] MAX_POS = LIMIT_W - 1'b1;
  localparam logic [ADDR_WIDTH:0] DEPTH_CNT = (ADDR_WIDTH + 1)'(DEPTH);

  state_t                  state;
  logic [DATA_WIDTH-1:0]   mag;
  logic [DATA_WIDTH-1:0]   wrap;
  logic                    neg;
  logic                    ovf_q;
  logic                    has_digit;

  logic                    accept;
  logic                    is_digit;
  logic                    is_sep;
  logic                    is_minus;
  logic                    in_idle;
  logic                    in_num;
  logic [3:0]              digit;
  logic [MW-1:0]           mag_ext;
  logic [MW-1:0]           mul;
  logic [DATA_WIDTH-1:0]   nxt_mag;
  logic [DATA_WIDTH-1:0]   nxt_wrap;
  logic                    nxt_ovf;
  logic [DATA_WIDTH-1:0]   eff_mag;
  logic [DATA_WIDTH-1:0]   eff_wrap;
  logic                    eff_ovf;
  logic                    out_of_range;
  logic [DATA_WIDTH-1:0]   commit_val;
  logic                    commit_req;
  logic                    invalid_req;
  logic                    acc_clr;
  logic                    acc_load;
  logic                    neg_set;

  assign state_dbg = state;
  assign digit     = pkt_payload_data[3:0];
  assign accept    = pkt_payload_valid && pkt_payload_ready;
  assign in_idle   = (state == S_IDLE);
  assign in_num    = (state == S_NUM);

  always_comb begin
    is_digit = (pkt_payload_data >= 8'h30) && (pkt_payload_data <= 8'h39);
    is_sep   = (pkt_payload_data == 8'h20) || (pkt_payload_data == 8'h2C) ||
               (pkt_payload_data == 8'h09) || (pkt_payload_data == 8'h0D) ||
               (pkt_payload_data == 8'h0A);
    is_minus = (pkt_payload_data == 8'h2D);

    // Magnitude saturates at 2^(W-1); wrap keeps the modulo-2^W value.
    mag_ext  = MW'(mag);
    mul      = (mag_ext << 3) + (mag_ext << 1) + MW'(digit);
    nxt_ovf  = ovf_q;
    nxt_mag  = mul[DATA_WIDTH-1:0];
    if (mul > LIMIT) begin
      nxt_mag = LIMIT_W;
      nxt_ovf = 1'b1;
    end
    nxt_wrap = (wrap << 3) + (wrap << 1) + DATA_WIDTH'(digit);

    // A terminating last digit is folded into the value it commits.
    eff_mag  = is_digit ? nxt_mag  : mag;
    eff_wrap = is_digit ? nxt_wrap : wrap;
    eff_ovf  = is_digit ? nxt_ovf  : ovf_q;
    out_of_range = eff_ovf || (!neg && (eff_mag == LIMIT_W));

    if (SAT_MODE != 0) begin
      commit_val = neg ? (-eff_mag) : (out_of_range ? MAX_POS : eff_mag);
    end else begin
      commit_val = neg ? (-eff_wrap) : eff_wrap;
    end

    commit_req  = accept && (((in_idle || in_num) && is_digit && pkt_payload_last) ||
                             (in_num && is_sep && has_digit));
    invalid_req = accept && (in_idle || in_num) &&
                  (!(is_digit || is_sep || is_minus) ||
                   (is_minus && (in_num || pkt_payload_last)) ||
                   (in_num && is_sep && !has_digit));

    acc_clr  = accept && (pkt_payload_last || invalid_req || (in_num && is_sep));
    acc_load = accept && !acc_clr && (in_idle || in_num) && is_digit;
    neg_set  = accept && !acc_clr && in_idle && is_minus;
  end

  always_ff @(posedge clk) begin
    if (rst || clear || acc_clr) begin
      mag       <= '0;
      wrap      <= '0;
      neg       <= 1'b0;
      ovf_q     <= 1'b0;
      has_digit <= 1'b0;
    end else if (acc_load) begin
      mag       <= nxt_mag;
      wrap      <= nxt_wrap;
      ovf_q     <= nxt_ovf;
      has_digit <= 1'b1;
    end else if (neg_set) begin
      neg       <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      state             <= S_IDLE;
      pkt_payload_ready <= 1'b1;
      wr_en             <= 1'b0;
      wr_addr           <= '0;
      wr_data           <= '0;
      done              <= 1'b0;
      invalid           <= 1'b0;
      overflow          <= 1'b0;
      full              <= 1'b0;
      num_count         <= '0;
    end else begin
      wr_en <= 1'b0;
      if (commit_req) begin
        if (out_of_range) overflow <= 1'b1;
        if (num_count == DEPTH_CNT) begin
          full <= 1'b1;
        end else begin
          wr_en     <= 1'b1;
          wr_addr   <= num_count[ADDR_WIDTH-1:0];
          wr_data   <= commit_val;
          num_count <= num_count + 1'b1;
        end
      end
      if (invalid_req) invalid <= 1'b1;

      if (accept) begin
        if (pkt_payload_last) begin
          state             <= S_DONE;
          pkt_payload_ready <= 1'b0;
          done              <= 1'b1;
        end else if (invalid_req) begin
          state <= S_ERR;
        end else begin
          case (state)
            S_IDLE:  if (is_digit || is_minus) state <= S_NUM;
            S_NUM:   if (is_sep) state <= S_IDLE;
            default: state <= state;
          endcase
        end
      end
    end
  end

endmodule

// File: tb/tb_ascii_num_stream_sep.sv
// Bench for ascii_num_stream_sep: three instances (32-bit default, 8-bit saturating,
// 8-bit wrapping, the 8-bit ones with DEPTH=4) checked against an expected-write queue.
module tb_ascii_num_stream_sep;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic            rst;
  logic [2:0][7:0] data;
  logic [2:0]      valid, last, clear;
  logic [2:0]      ready, wr_en, done, invalid, overflow, full;
  logic [2:0][11:0] waddr, cnt;
  logic [2:0][31:0] wdata;
  logic [2:0][1:0]  sdbg;

  logic [10:0] a0;
  logic [31:0] d0;
  logic [11:0] c0;
  logic [1:0]  a1, a2;
  logic [7:0]  d1, d2;
  logic [2:0]  c1, c2;

  ascii_num_stream_sep u_dut0 (
    .clk(clk), .rst(rst), .clear(clear[0]),
    .pkt_payload_data(data[0]), .pkt_payload_valid(valid[0]),
    .pkt_payload_last(last[0]), .pkt_payload_ready(ready[0]),
    .wr_en(wr_en[0]), .wr_addr(a0), .wr_data(d0),
    .done(done[0]), .invalid(invalid[0]), .overflow(overflow[0]), .full(full[0]),
    .num_count(c0), .state_dbg(sdbg[0])
  );

  ascii_num_stream_sep #(.DATA_WIDTH(8), .DEPTH(4), .ADDR_WIDTH(2), .SAT_MODE(1)) u_dut1 (
    .clk(clk), .rst(rst), .clear(clear[1]),
    .pkt_payload_data(data[1]), .pkt_payload_valid(valid[1]),
    .pkt_payload_last(last[1]), .pkt_payload_ready(ready[1]),
    .wr_en(wr_en[1]), .wr_addr(a1), .wr_data(d1),
    .done(done[1]), .invalid(invalid[1]), .overflow(overflow[1]), .full(full[1]),
    .num_count(c1), .state_dbg(sdbg[1])
  );

  ascii_num_stream_sep #(.DATA_WIDTH(8), .DEPTH(4), .ADDR_WIDTH(2), .SAT_MODE(0)) u_dut2 (
    .clk(clk), .rst(rst), .clear(clear[2]),
    .pkt_payload_data(data[2]), .pkt_payload_valid(valid[2]),
    .pkt_payload_last(last[2]), .pkt_payload_ready(ready[2]),
    .wr_en(wr_en[2]), .wr_addr(a2), .wr_data(d2),
    .done(done[2]), .invalid(invalid[2]), .overflow(overflow[2]), .full(full[2]),
    .num_count(c2), .state_dbg(sdbg[2])
  );

  assign waddr[0] = {1'b0, a0};
  assign wdata[0] = d0;
  assign cnt[0]   = c0;
  assign waddr[1] = {10'd0, a1};
  assign wdata[1] = {{24{d1[7]}}, d1};
  assign cnt[1]   = {9'd0, c1};
  assign waddr[2] = {10'd0, a2};
  assign wdata[2] = {{24{d2[7]}}, d2};
  assign cnt[2]   = {9'd0, c2};

  int n_tests = 0;
  int n_fail  = 0;
  logic [45:0] exp_q[$];
  logic [45:0] mon_got, mon_exp;

  // Scoreboard: entries are {unit, addr, sign-extended data}.
  always @(negedge clk) begin
    for (int u = 0; u < 3; u++) begin
      if (wr_en[u] === 1'b1) begin
        n_tests++;
        mon_got = {u[1:0], waddr[u], wdata[u]};
        if (exp_q.size() == 0) begin
          n_fail++;
          $display("FAIL write_unexpected: unit %0d got addr %0d data %0d, required no write",
                   u, waddr[u], $signed(wdata[u]));
        end else begin
          mon_exp = exp_q.pop_front();
          if (mon_got !== mon_exp) begin
            n_fail++;
            $display("FAIL write_value: got unit %0d addr %0d data %0d, required unit %0d addr %0d data %0d",
                     mon_got[45:44], mon_got[43:32], $signed(mon_got[31:0]),
                     mon_exp[45:44], mon_exp[43:32], $signed(mon_exp[31:0]));
          end
        end
      end
    end
  end

  function automatic logic [15:0] status(input int u);
    return {done[u], invalid[u], overflow[u], full[u], cnt[u]};
  endfunction

  task automatic expect_wr(input int u, input int addr, input int val);
    exp_q.push_back({u[1:0], addr[11:0], val[31:0]});
  endtask

  task automatic send_byte(input int u, input logic [7:0] b, input logic l);
    int waited;
    waited = 0;
    @(negedge clk);
    data[u] = b; valid[u] = 1'b1; last[u] = l;
    while (ready[u] !== 1'b1 && waited < 20) begin
      @(negedge clk);
      waited++;
    end
    if (waited >= 20) begin
      n_tests++; n_fail++;
      $display("FAIL handshake_timeout: unit %0d ready=%b, required 1", u, ready[u]);
    end
    @(posedge clk);
  endtask

  task automatic send_str(input int u, input string s, input logic last_end);
    for (int i = 0; i < s.len(); i++)
      send_byte(u, s[i], last_end && (i == s.len() - 1));
    @(negedge clk);
    valid[u] = 1'b0; last[u] = 1'b0;
  endtask

  task automatic do_clear(input int u);
    @(negedge clk);
    clear[u] = 1'b1;
    @(negedge clk);
    clear[u] = 1'b0;
  endtask

  task automatic wait_done(input int u, input string name);
    int k;
    k = 0;
    while (done[u] !== 1'b1 && k < 100) begin
      @(negedge clk);
      k++;
    end
    if (k >= 100) begin
      n_tests++; n_fail++;
      $display("FAIL %s_done_timeout: done=%b, required 1", name, done[u]);
    end
    repeat (2) @(negedge clk);
  endtask

  task automatic test_reset();
    rst = 1'b1; valid = '0; last = '0; clear = '0; data = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    n_tests++;
    if (ready[0] !== 1'b1 || wr_en[0] !== 1'b0) begin
      n_fail++; $display("FAIL reset_hs: ready=%b wr_en=%b, required 1 0", ready[0], wr_en[0]);
    end
    n_tests++;
    if (waddr[0] !== 12'd0 || wdata[0] !== 32'd0) begin
      n_fail++; $display("FAIL reset_wr: addr=%0d data=%0d, required 0 0", waddr[0], wdata[0]);
    end
    n_tests++;
    if (status(0) !== 16'd0 || status(1) !== 16'd0 || status(2) !== 16'd0) begin
      n_fail++; $display("FAIL reset_flags: %h %h %h, required 0", status(0), status(1), status(2));
    end
    n_tests++;
    if (sdbg[0] !== 2'd0) begin
      n_fail++; $display("FAIL reset_state: %0d, required 0", sdbg[0]);
    end
  endtask

  task automatic test_basic();
    expect_wr(0, 0, 12); expect_wr(0, 1, -7); expect_wr(0, 2, 0);
    send_str(0, "12 -7,0", 1'b1);
    wait_done(0, "basic");
    n_tests++;
    if (exp_q.size() != 0) begin
      n_fail++; $display("FAIL basic_writes: %0d missing, required 0", exp_q.size()); exp_q.delete();
    end
    n_tests++;
    if (status(0) !== {4'b1000, 12'd3}) begin
      n_fail++; $display("FAIL basic_status: %h, required %h", status(0), {4'b1000, 12'd3});
    end
  endtask

  task automatic test_done_hold();
    repeat (5) @(negedge clk);
    n_tests++;
    if (ready[0] !== 1'b0 || wr_en[0] !== 1'b0 || waddr[0] !== 12'd2 || sdbg[0] !== 2'd2) begin
      n_fail++;
      $display("FAIL done_hold: ready=%b wr_en=%b addr=%0d state=%0d, required 0 0 2 2",
               ready[0], wr_en[0], waddr[0], sdbg[0]);
    end
    n_tests++;
    if (status(0) !== {4'b1000, 12'd3}) begin
      n_fail++; $display("FAIL done_hold_flags: %h, required %h", status(0), {4'b1000, 12'd3});
    end
    do_clear(0);
    n_tests++;
    if (ready[0] !== 1'b1 || waddr[0] !== 12'd0 || wdata[0] !== 32'd0 || status(0) !== 16'd0) begin
      n_fail++;
      $display("FAIL clear_outputs: ready=%b addr=%0d data=%0d status=%h, required 1 0 0 0",
               ready[0], waddr[0], wdata[0], status(0));
    end
  endtask

  task automatic test_saturate();
    do_clear(1);
    expect_wr(1, 0, 127); expect_wr(1, 1, -128); expect_wr(1, 2, -128);
    send_str(1, "300 -200 -128", 1'b1);
    wait_done(1, "sat");
    n_tests++;
    if (exp_q.size() != 0) begin
      n_fail++; $display("FAIL sat_writes: %0d missing, required 0", exp_q.size()); exp_q.delete();
    end
    n_tests++;
    if (status(1) !== {4'b1010, 12'd3}) begin
      n_fail++; $display("FAIL sat_status: %h, required %h", status(1), {4'b1010, 12'd3});
    end
    do_clear(1);
    expect_wr(1, 0, 127); expect_wr(1, 1, -128);
    send_str(1, "127 -128", 1'b1);
    wait_done(1, "sat_edge");
    n_tests++;
    if (status(1) !== {4'b1000, 12'd2} || exp_q.size() != 0) begin
      n_fail++; $display("FAIL sat_edge_status: %h, required %h", status(1), {4'b1000, 12'd2});
      exp_q.delete();
    end
  endtask

  task automatic test_wrap();
    do_clear(2);
    expect_wr(2, 0, 44);
    send_str(2, "300", 1'b1);
    wait_done(2, "wrap");
    n_tests++;
    if (status(2) !== {4'b1010, 12'd1} || exp_q.size() != 0) begin
      n_fail++; $display("FAIL wrap_status: %h, required %h", status(2), {4'b1010, 12'd1});
      exp_q.delete();
    end
    do_clear(2);
    expect_wr(2, 0, -44);
    send_str(2, "-300", 1'b1);
    wait_done(2, "wrap_neg");
    n_tests++;
    if (status(2) !== {4'b1010, 12'd1} || exp_q.size() != 0) begin
      n_fail++; $display("FAIL wrap_neg_status: %h, required %h", status(2), {4'b1010, 12'd1});
      exp_q.delete();
    end
  endtask

  task automatic test_invalid();
    do_clear(0);
    expect_wr(0, 0, 5);
    send_str(0, "5 a 6", 1'b1);
    wait_done(0, "inv");
    n_tests++;
    if (status(0) !== {4'b1100, 12'd1} || exp_q.size() != 0) begin
      n_fail++; $display("FAIL inv_status: %h, required %h", status(0), {4'b1100, 12'd1});
      exp_q.delete();
    end
    do_clear(0);
    expect_wr(0, 0, 3);
    send_str(0, "3 -", 1'b1);
    wait_done(0, "dangling");
    n_tests++;
    if (status(0) !== {4'b1100, 12'd1} || exp_q.size() != 0) begin
      n_fail++; $display("FAIL dangling_status: %h, required %h", status(0), {4'b1100, 12'd1});
      exp_q.delete();
    end
    do_clear(0);
    send_str(0, "8-2 5", 1'b1);
    wait_done(0, "minus_after_digit");
    n_tests++;
    if (status(0) !== {4'b1100, 12'd0}) begin
      n_fail++; $display("FAIL minus_after_digit: %h, required %h", status(0), {4'b1100, 12'd0});
    end
  endtask

  task automatic test_seps_only();
    do_clear(0);
    send_str(0, " ,\t\015\012", 1'b1);
    wait_done(0, "seps");
    n_tests++;
    if (status(0) !== {4'b1000, 12'd0}) begin
      n_fail++; $display("FAIL seps_status: %h, required %h", status(0), {4'b1000, 12'd0});
    end
  endtask

  task automatic test_full();
    do_clear(1);
    for (int i = 0; i < 4; i++) expect_wr(1, i, i + 1);
    send_str(1, "1 2 3 4 5 6", 1'b1);
    wait_done(1, "full");
    n_tests++;
    if (status(1) !== {4'b1001, 12'd4} || exp_q.size() != 0) begin
      n_fail++; $display("FAIL full_status: %h, required %h", status(1), {4'b1001, 12'd4});
      exp_q.delete();
    end
  endtask

  task automatic test_clear_mid();
    do_clear(0);
    send_str(0, "12", 1'b0);
    do_clear(0);
    n_tests++;
    if (status(0) !== 16'd0 || sdbg[0] !== 2'd0) begin
      n_fail++; $display("FAIL clear_mid_abort: status=%h state=%0d, required 0 0", status(0), sdbg[0]);
    end
    expect_wr(0, 0, 9);
    send_str(0, "9", 1'b1);
    wait_done(0, "clear_mid");
    n_tests++;
    if (status(0) !== {4'b1000, 12'd1} || exp_q.size() != 0) begin
      n_fail++; $display("FAIL clear_mid_status: %h, required %h", status(0), {4'b1000, 12'd1});
      exp_q.delete();
    end
  endtask

  task automatic test_back_to_back();
    string s;
    string seps;
    int v, n;
    seps = " ,\t\015\012";
    do_clear(0);
    s = "";
    n = $urandom_range(4, 9);
    for (int i = 0; i < n; i++) begin
      v = int'($urandom_range(0, 2000000)) - 1000000;
      expect_wr(0, i, v);
      s = {s, $sformatf("%0d", v)};
      if (i != n - 1)
        repeat ($urandom_range(1, 2)) s = {s, $sformatf("%c", seps[$urandom_range(0, 4)])};
    end
    send_str(0, s, 1'b1);
    wait_done(0, "b2b");
    n_tests++;
    if (status(0) !== {4'b1000, n[11:0]} || exp_q.size() != 0) begin
      n_fail++; $display("FAIL b2b_status: %h, required %h", status(0), {4'b1000, n[11:0]});
      exp_q.delete();
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

  initial begin
    test_reset();
    test_basic();
    test_done_hold();
    test_saturate();
    test_wrap();
    test_invalid();
    test_seps_only();
    test_full();
    test_clear_mid();
    test_back_to_back();
    test_back_to_back();
    repeat (3) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
